// File: rtl/foo_accum_arbiter.sv
// Round-robin arbiter sequencing NUM_REQ requesters onto one shared
// accumulate-plus-one datapath (accum <= accum + a + 1). Each accepted
// request is answered with the post-update accumulator value and the
// requester's index.
module foo_accum_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned DATA_W  = 64,
  localparam int unsigned ID_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*DATA_W-1:0] req_a,
  input  logic                      clear,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [ID_W-1:0]           rsp_id,
  output logic [DATA_W-1:0]         rsp_data,
  output logic                      busy
);

  typedef enum logic [1:0] {StIdle, StAccum, StResp} state_e;

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   accum_q, accum_d;
  logic [DATA_W-1:0]   a_q, a_d;
  logic [ID_W-1:0]     id_q, id_d;
  logic [ID_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic                clear_pend_q, clear_pend_d;

  logic                grant_found;
  logic [ID_W-1:0]     grant_idx;
  logic [ID_W-1:0]     cand;

  // Round-robin search: first valid requester at or after rr_ptr, wrapping.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      cand = ID_W'((32'(rr_ptr_q) + i) % NUM_REQ);
      if (!grant_found && req_valid[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  // Next-state logic, datapath update and the combinational accept strobe.
  always_comb begin
    state_d      = state_q;
    accum_d      = accum_q;
    a_d          = a_q;
    id_d         = id_q;
    rr_ptr_d     = rr_ptr_q;
    clear_pend_d = clear_pend_q;
    req_ready    = '0;

    unique case (state_q)
      StIdle: begin
        // A pending or live clear beats any grant in the same cycle.
        if (clear || clear_pend_q) begin
          accum_d      = '0;
          clear_pend_d = 1'b0;
        end else if (grant_found && rst_n) begin
          req_ready[grant_idx] = 1'b1;
          a_d                  = req_a[32'(grant_idx) * DATA_W +: DATA_W];
          id_d                 = grant_idx;
          state_d              = StAccum;
        end
      end
      StAccum: begin
        accum_d = accum_q + a_q + DATA_W'(1);
        if (clear) clear_pend_d = 1'b1;
        state_d = StResp;
      end
      StResp: begin
        // Clear is deferred so the in-flight response keeps its value.
        if (clear) clear_pend_d = 1'b1;
        if (rsp_ready) begin
          rr_ptr_d = (id_q == ID_W'(NUM_REQ - 1)) ? '0 : id_q + ID_W'(1);
          state_d  = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      accum_q      <= '0;
      a_q          <= '0;
      id_q         <= '0;
      rr_ptr_q     <= '0;
      clear_pend_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      accum_q      <= accum_d;
      a_q          <= a_d;
      id_q         <= id_d;
      rr_ptr_q     <= rr_ptr_d;
      clear_pend_q <= clear_pend_d;
    end
  end

  assign rsp_valid = (state_q == StResp);
  assign rsp_data  = rsp_valid ? accum_q : '0;
  assign rsp_id    = rsp_valid ? id_q : '0;
  assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_foo_accum_arbiter.sv
// Bench for foo_accum_arbiter: directed scenarios plus randomized traffic,
// checked against a simple arithmetic model of the accumulator and arbiter.
module tb_foo_accum_arbiter;

  localparam int unsigned NR = 4;
  localparam int unsigned DW = 64;

  logic            clk;
  logic            rst_n;
  logic [NR-1:0]   req_valid;
  logic [NR-1:0]   req_ready;
  logic [NR*DW-1:0] req_a;
  logic            clear;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [1:0]      rsp_id;
  logic [DW-1:0]   rsp_data;
  logic            busy;

  foo_accum_arbiter #(.NUM_REQ(NR), .DATA_W(DW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .clear     (clear),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  logic [DW-1:0] m_acc;
  int            m_ptr;
  logic [DW-1:0] ops [NR];

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_ops();
    req_a = {ops[3], ops[2], ops[1], ops[0]};
  endtask

  // One full request/response transaction; vmask must be non-zero.
  task automatic run_txn(input logic [NR-1:0] vmask, input int hold);
    int g;
    logic [DW-1:0] exp_data;
    logic [NR-1:0] exp_ready;
    g = -1;
    for (int i = 0; i < NR; i++)
      if (g < 0 && vmask[(m_ptr + i) % NR]) g = (m_ptr + i) % NR;
    exp_ready = '0;
    exp_ready[g] = 1'b1;
    exp_data = m_acc + ops[g] + 64'd1;

    @(negedge clk);
    req_valid = vmask;
    drive_ops();
    rsp_ready = (hold == 0);
    #1;
    chk("grant_ready", 64'(req_ready), 64'(exp_ready));
    chk("idle_busy", 64'(busy), 64'd0);
    @(posedge clk); #1;
    chk("accum_busy", 64'(busy), 64'd1);
    chk("accum_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("accum_ready", 64'(req_ready), 64'd0);
    @(posedge clk); #1;
    chk("rsp_valid", 64'(rsp_valid), 64'd1);
    chk("rsp_id", 64'(rsp_id), 64'(g));
    chk("rsp_data", rsp_data, exp_data);
    for (int c = 0; c < hold; c++) begin
      @(posedge clk); #1;
      chk("hold_valid", 64'(rsp_valid), 64'd1);
      chk("hold_id", 64'(rsp_id), 64'(g));
      chk("hold_data", rsp_data, exp_data);
      chk("hold_ready", 64'(req_ready), 64'd0);
      chk("hold_busy", 64'(busy), 64'd1);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    chk("back_idle_busy", 64'(busy), 64'd0);
    chk("back_idle_valid", 64'(rsp_valid), 64'd0);
    req_valid = '0;
    m_acc = exp_data;
    m_ptr = (g + 1) % NR;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #2;
    chk("rst_ready", 64'(req_ready), 64'd0);
    chk("rst_valid", 64'(rsp_valid), 64'd0);
    chk("rst_id", 64'(rsp_id), 64'd0);
    chk("rst_data", rsp_data, 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    m_acc = '0;
    m_ptr = 0;
  endtask

  initial begin
    req_valid = '0;
    clear     = 1'b0;
    rsp_ready = 1'b1;
    for (int i = 0; i < NR; i++) ops[i] = '0;
    drive_ops();

    // 1: basic single requester
    do_reset();
    ops[0] = 64'd5;
    run_txn(4'b0001, 0);
    chk("t1_first", m_acc, 64'd6);
    run_txn(4'b0001, 0);
    chk("t1_second_data", rsp_data, 64'd0);
    chk("t1_model", m_acc, 64'd12);

    // 2: all four valid, a=0 -> rotating grants
    do_reset();
    for (int i = 0; i < NR; i++) ops[i] = '0;
    for (int k = 0; k < 5; k++) run_txn(4'b1111, 0);
    chk("t2_acc", m_acc, 64'd5);

    // 3: response backpressure
    ops[2] = 64'd10;
    run_txn(4'b0100, 10);

    // 4: wrap-around
    do_reset();
    ops[3] = 64'hFFFF_FFFF_FFFF_FFFD;
    run_txn(4'b1000, 0);
    ops[3] = '0;
    run_txn(4'b1000, 0);
    chk("t4_max", m_acc, 64'hFFFF_FFFF_FFFF_FFFF);
    run_txn(4'b1000, 0);
    chk("t4_wrap", m_acc, 64'd0);

    // 5: clear during RESP, then clear together with req_valid in IDLE
    do_reset();
    ops[0] = 64'd6;
    @(negedge clk);
    req_valid = 4'b0001;
    drive_ops();
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("t5_rsp_pre", rsp_data, 64'd7);
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    req_valid = 4'b0001;
    #1;
    chk("t5_pend_no_grant", 64'(req_ready), 64'd0);
    @(posedge clk);
    m_acc = '0;
    m_ptr = 1;
    req_valid = '0;
    ops[0] = 64'd2;
    run_txn(4'b0001, 0);
    chk("t5_after_clear", m_acc, 64'd3);
    @(negedge clk);
    clear = 1'b1;
    req_valid = 4'b0010;
    #1;
    chk("t5_clear_wins", 64'(req_ready), 64'd0);
    @(posedge clk); #1;
    clear = 1'b0;
    req_valid = '0;
    m_acc = '0;
    chk("t5_clear_busy", 64'(busy), 64'd0);

    // 6: reset in ACCUM
    @(negedge clk);
    ops[1] = 64'd9;
    drive_ops();
    req_valid = 4'b0010;
    @(posedge clk); #1;
    req_valid = '0;
    rst_n = 1'b0;
    #1;
    chk("t6_busy", 64'(busy), 64'd0);
    chk("t6_valid", 64'(rsp_valid), 64'd0);
    chk("t6_data", rsp_data, 64'd0);
    chk("t6_ready", 64'(req_ready), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    m_acc = '0;
    m_ptr = 0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      chk("t6_no_stale", 64'(rsp_valid), 64'd0);
    end
    ops[0] = 64'd1;
    run_txn(4'b0001, 0);
    chk("t6_after", m_acc, 64'd2);

    // Randomized traffic against the model
    for (int k = 0; k < 40; k++) begin
      for (int i = 0; i < NR; i++) ops[i] = {$urandom(), $urandom()};
      run_txn(NR'($urandom_range(1, 15)), int'($urandom_range(0, 2)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
